// File: rtl/saboteur_pkg.sv
// Shared constants and helpers for the saboteur scan blocks.
// FSM encodings and a width helper used for counter sizing.
package saboteur_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Shift-rate divider: one-cycle registered tick every DIV cycles.
// o_DUE says the cycle being entered next is a tick slot.
module shift_tick_gen
  import saboteur_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_EN,
  output logic o_DUE,
  output logic o_TICK
);

  localparam int DW = clog2(DIV) + 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] r_cnt;
  logic          r_tick;

  assign o_DUE  = (r_cnt == '0);
  assign o_TICK = r_tick;

  // Phase restarts at zero whenever the enable drops.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_EN) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_DUE;
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/saboteur_scan_loader.sv
// Serialises a fault-mask word LSB-first into the saboteur chain,
// then strobes update so the chain commits the mask.
module saboteur_scan_loader
  import saboteur_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int SHIFT_DIV = 1
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  input  logic [WIDTH-1:0] i_DATA,
  output logic             o_READY,
  input  logic             i_ABORT,
  output logic             o_SR_EN,
  output logic             o_SR_SI,
  output logic             o_UPDATE,
  output logic             o_BUSY
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ready;
  logic             r_busy;
  logic             r_upd;
  logic             r_si;
  logic             w_due;
  logic             w_tick;
  logic             w_take;
  logic             w_fire;
  logic             w_en;

  assign o_READY  = r_ready;
  assign o_BUSY   = r_busy;
  assign o_UPDATE = r_upd;
  assign o_SR_SI  = r_si;
  assign o_SR_EN  = w_tick;

  assign w_take = (r_state == ST_IDLE) && r_ready
                  && i_VALID && !i_ABORT;
  assign w_en   = (w_next == ST_SHIFT);
  assign w_fire = w_en && w_due;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_take) w_next = ST_SHIFT;
      ST_SHIFT:
        if (i_ABORT)
          w_next = ST_IDLE;
        else if (w_due && r_bitcnt == LAST_BIT)
          w_next = ST_UPDATE;
      ST_UPDATE:
        w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  shift_tick_gen #(
    .DIV (SHIFT_DIV)
  ) u_tick (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_EN   (w_en),
    .o_DUE  (w_due),
    .o_TICK (w_tick)
  );

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shadow <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_upd    <= 1'b0;
      r_si     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE) && !i_ABORT;
      r_busy  <= (w_next != ST_IDLE);
      r_upd   <= (w_next == ST_UPDATE);
      // Shadow holds the bits not yet sent; bit 0 goes out first.
      if (w_take) begin
        r_shadow <= i_DATA >> 1;
        r_si     <= i_DATA[0];
        r_bitcnt <= CW'(1);
      end else if (w_fire) begin
        r_shadow <= r_shadow >> 1;
        r_si     <= r_shadow[0];
        r_bitcnt <= r_bitcnt + 1'b1;
      end else if (!w_en) begin
        r_si     <= 1'b0;
        r_bitcnt <= '0;
      end
    end
  end

endmodule

// File: doc/saboteur_scan_loader.md
Name: saboteur_scan_loader

Overview:
Upstream feeder for the saboteur shift register. It accepts a parallel WIDTH-bit fault-mask word through a valid/ready handshake and serialises it LSB-first onto the serial-in/enable pair of the shift register. After the last bit it issues a one-cycle update strobe so the downstream saboteur can commit the mask. An optional divider slows the shift rate for long scan chains.

Parameters:
WIDTH, 10, mask word length; must equal the downstream shift register WIDTH; minimum 2.
SHIFT_DIV, 1, clock cycles per shifted bit; minimum 1.

Ports:
i_CLK  input  1  clock, rising edge.
i_RST  input  1  asynchronous, active-low reset.
i_VALID  input  1  mask word on i_DATA is valid.
i_DATA  input  WIDTH  mask word to load.
o_READY  output  1  loader can accept a word.
i_ABORT  input  1  cancel the current load; synchronous, level-sampled.
o_SR_EN  output  1  shift enable to the shift register.
o_SR_SI  output  1  serial data to the shift register.
o_UPDATE  output  1  one-cycle strobe: the mask is fully shifted in.
o_BUSY  output  1  a load is in progress.

Behaviour:
- Reset (i_RST=0, async): state IDLE; all outputs 0; bit counter, divider and data register cleared. o_READY rises on the first rising edge after reset release.
- All outputs are registered. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE -> SHIFT on the edge where i_VALID=1 and o_READY=1. On that edge i_DATA is captured into the shadow register.
  - SHIFT -> UPDATE after WIDTH shift ticks.
  - UPDATE -> IDLE after one cycle.
  - SHIFT -> IDLE when i_ABORT=1.
- IDLE: o_READY=1, o_BUSY=0, o_SR_EN=0.
- SHIFT: o_READY=0, o_BUSY=1.
  - A tick occurs every SHIFT_DIV cycles; the first tick is in the first SHIFT cycle.
  - On a tick cycle, o_SR_EN=1 and o_SR_SI = shadow bit n, where n = 0..WIDTH-1 is the tick index (LSB first). On all other cycles o_SR_EN=0.
  - o_SR_SI holds its value between ticks.
  - Because the shift register inserts at the MSB and shifts right, after WIDTH ticks its parallel output equals the captured word.
- UPDATE: o_UPDATE=1 for exactly one cycle, o_SR_EN=0, o_BUSY=1, o_READY=0.
- Latency with SHIFT_DIV=1, handshake on edge 0:
  - o_SR_EN high in cycles 1..WIDTH.
  - o_UPDATE high in cycle WIDTH+1.
  - o_READY high again from cycle WIDTH+2.
- Latency in general: UPDATE occurs WIDTH*SHIFT_DIV+1 cycles after the handshake.
- Counters:
  - Bit counter width is clog2(WIDTH+1).
  - Divider counter width is clog2(SHIFT_DIV)+1 and wraps at SHIFT_DIV-1.
  - No overflow is possible.
- i_VALID while busy is ignored: no capture and no queueing. The upstream must hold i_VALID until o_READY.
- i_ABORT:
  - In SHIFT: next cycle is IDLE; o_SR_EN and o_SR_SI go to 0; no o_UPDATE. The partially shifted chain contents are undefined for the consumer.
  - In UPDATE: ignored; the strobe completes.
  - In IDLE: blocks acceptance. o_READY is deasserted the cycle after i_ABORT is seen high.
- i_VALID and i_ABORT both high in IDLE: abort wins; no capture.
- Reset mid-shift: immediate return to the reset values; no o_UPDATE.
- Back-to-back loads: a new word may be accepted on the first IDLE edge after UPDATE. There is no dead cycle beyond that.

Decomposition:
- Package saboteur_pkg holds:
  - the state encoding constants: ST_IDLE, ST_SHIFT, ST_UPDATE (2-bit);
  - a clog2 helper function shared with other saboteur blocks.
- One natural sub-module: shift_tick_gen. It is the SHIFT_DIV divider, producing a one-cycle tick while enabled, and resets its phase whenever the enable drops.
- The FSM, bit counter and shadow register stay in the top module.

Test Plan:
- WIDTH=10, SHIFT_DIV=1, load 0x2A5 -> o_SR_SI on the EN cycles reads 1,0,1,0,0,1,0,1,0,1; the attached shift-register model outputs 0x2A5 when o_UPDATE pulses in cycle 11.
- SHIFT_DIV=3, load 0x3FF -> o_SR_EN pulses at cycles 1,4,...,28, one cycle wide; o_UPDATE at cycle 31; model outputs 0x3FF.
- Back-to-back 0x155 then 0x0AA with i_VALID held high -> the second handshake occurs exactly on the first IDLE edge after UPDATE; the model shows 0x155 then 0x0AA; no bit slip.
- i_VALID pulsed with 0x001 while busy loading 0x200 -> ignored; only 0x200 is loaded and one o_UPDATE is seen.
- i_ABORT asserted after 4 ticks -> next cycle o_BUSY=0, o_SR_EN=0, no o_UPDATE, o_READY=1 afterwards; a new 0x123 then loads correctly.
- i_RST pulled low mid-shift (async, between edges) -> all outputs 0 immediately; after release o_READY=1 on the first edge and no o_UPDATE occurs.
